// File: rtl/rr_arbiter_4_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4_if
// Request/grant bundle between four requesters and the round-robin arbiter.
//   req       : request vector, bit n = requester n wants the grant
//   gnt_idx   : index of the current grant holder (decoder select)
//   gnt_valid : gnt_idx names an active grant
//   gnt_new   : one-cycle pulse on the first cycle of each grant
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter_4_if;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             gnt_new;

    modport master (
        output req,
        input  gnt_idx,
        input  gnt_valid,
        input  gnt_new
    );

    modport slave (
        input  req,
        output gnt_idx,
        output gnt_valid,
        output gnt_new
    );
endinterface : rr_arbiter_4_if

// File: rtl/rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4
// Four-requester round-robin arbiter with a bounded grant hold. A holder keeps
// the grant while it requests, but once it has held for HOLD_MAX cycles and
// someone else is waiting, the grant moves on. All outputs are registered.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   arb : rr_arbiter_4_if.slave (req in; gnt_idx, gnt_valid, gnt_new out)
// ---------------------------------------------------------------------------
module rr_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_4_if.slave  arb
);
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Rotating search: first set bit of mask, starting at start, wrapping mod 4.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] f_search(
        input logic [IDX_W-1:0] start,
        input logic [N_REQ-1:0] mask
    );
        logic             found;
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        win   = start;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = start + IDX_W'(i);
            if (!found && mask[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return {found, win};
    endfunction

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_gnt_new;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_valid_nxt;
    logic             w_new_nxt;

    logic [N_REQ-1:0] w_req_other;
    logic             w_holder_req;
    logic [IDX_W-1:0] w_ptr_rot;
    logic [IDX_W:0]   w_search_idle;
    logic [IDX_W:0]   w_search_move;
    logic             w_hold_full;

    // Requests from everyone but the current holder; the holder is never
    // picked first on release or preempt.
    assign w_req_other   = arb.req & ~(N_REQ'(1) << r_gnt_idx);
    assign w_holder_req  = arb.req[r_gnt_idx];
    assign w_ptr_rot     = r_gnt_idx + IDX_W'(1);
    assign w_search_idle = f_search(r_ptr, arb.req);
    assign w_search_move = f_search(w_ptr_rot, w_req_other);
    assign w_hold_full   = (r_hold_cnt >= HOLD_LIM);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_new   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_gnt_new   <= w_new_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_idx_nxt   = r_gnt_idx;
        w_valid_nxt = r_gnt_valid;
        w_new_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_search_idle[IDX_W]) begin
                    w_state_nxt = ST_GRANT;
                    w_idx_nxt   = w_search_idle[IDX_W-1:0];
                    w_valid_nxt = 1'b1;
                    w_new_nxt   = 1'b1;
                    w_hold_nxt  = CNT_W'(1);
                end
            end

            ST_GRANT: begin
                if (!w_holder_req) begin
                    // Release: hand straight over if anyone else wants it.
                    w_ptr_nxt = w_ptr_rot;
                    if (w_search_move[IDX_W]) begin
                        w_idx_nxt   = w_search_move[IDX_W-1:0];
                        w_valid_nxt = 1'b1;
                        w_new_nxt   = 1'b1;
                        w_hold_nxt  = CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if (w_hold_full && (|w_req_other)) begin
                    // Preempt: hold budget spent and someone else is waiting.
                    w_ptr_nxt   = w_ptr_rot;
                    w_idx_nxt   = w_search_move[IDX_W-1:0];
                    w_valid_nxt = 1'b1;
                    w_new_nxt   = 1'b1;
                    w_hold_nxt  = CNT_W'(1);
                end else begin
                    // Continue: count up, saturating at the hold limit.
                    w_valid_nxt = 1'b1;
                    if (!w_hold_full) begin
                        w_hold_nxt = r_hold_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign arb.gnt_idx   = r_gnt_idx;
    assign arb.gnt_valid = r_gnt_valid;
    assign arb.gnt_new   = r_gnt_new;

endmodule : rr_arbiter_4

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter with bounded grant hold.
- Produces a registered 2-bit grant index and a valid flag.
- The index drives the select input of the downstream 2-to-4 decoder, which regenerates the one-hot grant lines.
- Its sequential core is the rotating priority pointer, a hold counter and a small FSM.

Parameters:
HOLD_MAX, 8, max consecutive cycles one requester keeps the grant while any other requester is waiting; legal range 1..255

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  4  request vector; req[n] high = requester n wants the grant
gnt_idx  output  2  index of the current grant holder (decoder select)
gnt_valid  output  1  high while gnt_idx names an active grant
gnt_new  output  1  one-cycle pulse on the first cycle of every new grant, including a handover

Behaviour:
- Single clock domain. All outputs are registered, with no combinational path from req to any output.
- Reset:
  - Reset is synchronous and active-high, sampled on the clk rising edge, and takes priority over all other activity.
  - Reset values: gnt_idx=2'b00, gnt_valid=0, gnt_new=0.
  - Internal reset values: ptr=2'b00, hold_cnt=0, state=IDLE.
- Internal state:
  - ptr (2 bits) holds the highest-priority index for the next search.
  - hold_cnt is 8 bits and saturates at HOLD_MAX.
- Search function: starting at ptr, scan ptr, ptr+1, ptr+2, ptr+3 (mod 4 wrap). The first set req bit wins.
- States: IDLE, GRANT.
- IDLE:
  - req==0: remain in IDLE. gnt_valid=0, and gnt_idx keeps its last value.
  - req!=0: on the next edge, go to GRANT with gnt_idx=winner, gnt_valid=1, gnt_new=1, hold_cnt=1.
  - Latency from a req assertion sampled in IDLE to gnt_valid high is exactly 1 cycle.
- GRANT, holder h=gnt_idx:
  - Release (req[h]==0):
    - Set ptr=h+1 mod 4, then search among the other requesters.
    - If a winner exists: on the next edge, gnt_idx=winner, gnt_new=1, hold_cnt=1, gnt_valid stays 1 (no bubble).
    - Otherwise: go to IDLE with gnt_valid=0.
  - Continue (req[h]==1, and hold_cnt<HOLD_MAX or no other req set): keep the grant. hold_cnt increments, saturating at HOLD_MAX. gnt_new=0.
  - Preempt (req[h]==1, hold_cnt==HOLD_MAX, and some other req bit set):
    - Set ptr=h+1 mod 4 and search excluding h.
    - On the next edge, the new holder gets the grant with gnt_new=1 and hold_cnt=1.
    - The old holder is not re-granted until a full rotation completes.
  - Search order always excludes the current holder on release or preempt, so h is never chosen first.
- gnt_new is high for exactly one cycle per grant start and is otherwise 0.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,... Each holder keeps the grant for exactly HOLD_MAX cycles.
- HOLD_MAX=1: under contention, the grant moves every cycle.
- Simultaneous release and new requests in the same cycle: the release rule applies, using that cycle's req.
- Reset mid-grant: on the next edge, outputs return to reset values. The old holder gets no grant continuation, and ptr returns to 0.
- req bits may change every cycle. Only values sampled at the clk edge matter.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt_valid=0, gnt_new=0, gnt_idx=00 throughout. After rst falls, the first grant is idx 0 one cycle later, with gnt_new=1.
2. Single requester: req=4'b0100 from IDLE -> one cycle later gnt_idx=10, gnt_valid=1, gnt_new=1. Hold req for 20 cycles -> grant is held, gnt_new stays 0, no preempt. Drop req -> gnt_valid=0 the next cycle.
3. Full contention with HOLD_MAX=8: req=4'b1111 for 40 cycles -> gnt_idx sequence 0,1,2,3,0 with each index held 8 cycles. gnt_new pulses at cycles 1, 9, 17, 25, 33 after the start.
4. Release handover with no bubble: holder 1 (req=4'b0011, then req becomes 4'b0001) -> the next cycle gnt_idx=00, gnt_valid stays 1, gnt_new=1.
5. Wrap-around: holder 3 with req=4'b1010, holder 3 releases -> the search wraps 0 then 1, so gnt_idx=01 next. Repeat with HOLD_MAX=1 and req=4'b1001 -> the grant alternates 3,0,3,0 every cycle.
6. Reset mid-operation: during scenario 3 while idx 2 is held, assert rst for 1 cycle -> the next edge gives gnt_valid=0 and gnt_idx=00. The re-grant after reset starts at idx 0.
